// File: rtl/cnn_sched_pkg.sv
// rtl/cnn_sched_pkg.sv - shared types, kernel geometry and width helper for the row scheduler
package cnn_sched_pkg;

    localparam int KERNEL_WIDTH = 3;
    localparam int KERNEL_SIZE  = KERNEL_WIDTH * KERNEL_WIDTH;

    // Bits needed to index 'value' entries; never returns less than 1 so a
    // single-entry dimension still gets a real (1-bit) counter.
    function automatic int C_LOG_2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width = width + 1;
        return width;
    endfunction

    localparam int WEI_INDEX_WIDTH = C_LOG_2(KERNEL_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_EN,
        ST_SCAN,
        ST_WAIT_PE,
        ST_PULSE,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/kernel_row_ffs.sv
// rtl/kernel_row_ffs.sv - find-first-set over one kernel-row weight group from a start column
//
// Ports:
//   group     in  WIDTH : non-zero weight flags of one kernel row, bit c = column c
//   start_col in  COL_W : lowest column allowed to match
//   found     out 1     : a set bit exists at column >= start_col
//   col       out COL_W : lowest such column (0 when not found)
module kernel_row_ffs #(
    parameter int WIDTH = 3,
    parameter int COL_W = 2
) (
    input  logic [WIDTH-1:0] group,
    input  logic [COL_W-1:0] start_col,
    output logic             found,
    output logic [COL_W-1:0] col
);

    // Scan from the top down so the lowest qualifying column is the last write.
    always_comb begin
        found = 1'b0;
        col   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (group[i] && (i >= int'(start_col))) begin
                found = 1'b1;
                col   = COL_W'(i);
            end
        end
    end

endmodule

// File: rtl/pe_row_scheduler.sv
// rtl/pe_row_scheduler.sv - row/weight pass sequencer driving mem_controller and the PE column
//
// Ports:
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   mode               : 1 = serial row mode, 0 = parallel block mode (sampled on go)
//   cfg_load           : load cfg_wei_flag into the weight-flag register (idle only)
//   cfg_wei_flag       : non-zero weight bitmap, bit KERNEL_WIDTH*kr+c
//   go                 : start a layer pass (idle only)
//   mc_en              : mem_controller buffers loaded
//   pe_done            : PE finished the current weight pass
//   mc_start           : one-cycle start pulse to mem_controller
//   row_finish_done_0  : a PE pass completed
//   row_cal_done       : kernel row (mode 1) or weight position (mode 0) completed
//   wei_index          : weight position in flight
//   row_index          : current feature-map row
//   busy, done         : pass in progress / one-cycle end-of-pass pulse
//   protocol_err       : sticky, pe_done seen outside the PE wait
module pe_row_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int IF_WIDTH        = 16,
    parameter int KERNEL_WIDTH    = cnn_sched_pkg::KERNEL_WIDTH,
    parameter int KERNEL_SIZE     = KERNEL_WIDTH * KERNEL_WIDTH,
    parameter int ACT_INDEX_WIDTH = C_LOG_2(IF_WIDTH),
    parameter int WEI_INDEX_WIDTH = C_LOG_2(KERNEL_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mode,
    input  logic                       cfg_load,
    input  logic [KERNEL_SIZE-1:0]     cfg_wei_flag,
    input  logic                       go,
    input  logic                       mc_en,
    input  logic                       pe_done,
    output logic                       mc_start,
    output logic                       row_finish_done_0,
    output logic                       row_cal_done,
    output logic [WEI_INDEX_WIDTH-1:0] wei_index,
    output logic [ACT_INDEX_WIDTH-1:0] row_index,
    output logic                       busy,
    output logic                       done,
    output logic                       protocol_err
);

    localparam int KR_W  = C_LOG_2(KERNEL_WIDTH);
    localparam int COL_W = KR_W;

    localparam logic [KR_W-1:0]            KR_LAST  = KR_W'(KERNEL_WIDTH - 1);
    localparam logic [WEI_INDEX_WIDTH-1:0] POS_LAST = WEI_INDEX_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [ACT_INDEX_WIDTH-1:0] ROW_LAST = ACT_INDEX_WIDTH'(IF_WIDTH - 1);

    sched_state_t               state_q, state_nxt;
    logic                       mode_q, mode_nxt;
    logic [KERNEL_SIZE-1:0]     flag_q, flag_nxt;
    logic [KR_W-1:0]            kr_q, kr_nxt;
    // Mode 1: next column to search in the current group. Mode 0: weight position.
    logic [WEI_INDEX_WIDTH-1:0] wei_ptr_q, wei_ptr_nxt;
    // The pass in flight closes its group (mode 1) or position (mode 0).
    logic                       last_q, last_nxt;

    logic                       mc_start_nxt, rfd_nxt, cal_nxt, done_nxt, busy_nxt, err_nxt;
    logic [WEI_INDEX_WIDTH-1:0] wei_index_nxt;
    logic [ACT_INDEX_WIDTH-1:0] row_index_nxt;
    logic                       row_end;

    logic [KERNEL_SIZE-1:0]     flag_shift;
    logic [KERNEL_WIDTH-1:0]    group;
    logic [KERNEL_WIDTH-1:0]    group_rest;
    logic [COL_W-1:0]           start_col;
    logic                       ffs_found;
    logic [COL_W-1:0]           ffs_col;
    logic [KERNEL_SIZE-1:0]     pos_shift;
    logic                       pos_set;
    logic [WEI_INDEX_WIDTH-1:0] grp_base;
    logic [WEI_INDEX_WIDTH-1:0] grp_index;

    assign flag_shift = flag_q >> (KERNEL_WIDTH * int'(kr_q));
    assign group      = flag_shift[KERNEL_WIDTH-1:0];
    assign start_col  = COL_W'(wei_ptr_q);

    kernel_row_ffs #(
        .WIDTH (KERNEL_WIDTH),
        .COL_W (COL_W)
    ) u_ffs (
        .group     (group),
        .start_col (start_col),
        .found     (ffs_found),
        .col       (ffs_col)
    );

    // Nothing set above the found column means this pass ends the group.
    assign group_rest = group >> (int'(ffs_col) + 1);
    assign grp_base   = WEI_INDEX_WIDTH'(KERNEL_WIDTH * int'(kr_q));
    assign grp_index  = WEI_INDEX_WIDTH'(KERNEL_WIDTH * int'(kr_q) + int'(ffs_col));

    assign pos_shift  = flag_q >> wei_ptr_q;
    assign pos_set    = pos_shift[0];

    always_comb begin
        state_nxt     = state_q;
        mode_nxt      = mode_q;
        flag_nxt      = flag_q;
        kr_nxt        = kr_q;
        wei_ptr_nxt   = wei_ptr_q;
        last_nxt      = last_q;
        mc_start_nxt  = 1'b0;
        rfd_nxt       = 1'b0;
        cal_nxt       = 1'b0;
        done_nxt      = 1'b0;
        wei_index_nxt = wei_index;
        row_index_nxt = row_index;
        row_end       = 1'b0;
        err_nxt       = protocol_err | (pe_done & (state_q != ST_WAIT_PE));

        unique case (state_q)
            ST_IDLE: begin
                // A load in the same cycle as go is visible to the pass,
                // since the flag is only read from SCAN onwards.
                if (cfg_load) flag_nxt = cfg_wei_flag;
                if (go) begin
                    state_nxt     = ST_START;
                    mode_nxt      = mode;
                    kr_nxt        = '0;
                    wei_ptr_nxt   = '0;
                    row_index_nxt = '0;
                    wei_index_nxt = '0;
                    mc_start_nxt  = 1'b1;
                    err_nxt       = 1'b0;
                end
            end

            ST_START: state_nxt = ST_WAIT_EN;

            ST_WAIT_EN: if (mc_en) state_nxt = ST_SCAN;

            ST_SCAN: begin
                if (mode_q) begin
                    if (ffs_found) begin
                        wei_index_nxt = grp_index;
                        wei_ptr_nxt   = WEI_INDEX_WIDTH'(int'(ffs_col) + 1);
                        last_nxt      = (group_rest == '0);
                        state_nxt     = ST_WAIT_PE;
                    end else begin
                        // Only reachable for an all-zero group: a non-empty
                        // group is closed by its last pass.
                        wei_index_nxt = grp_base;
                        last_nxt      = 1'b1;
                        cal_nxt       = 1'b1;
                        state_nxt     = ST_PULSE;
                    end
                end else begin
                    wei_index_nxt = wei_ptr_q;
                    last_nxt      = 1'b1;
                    if (pos_set) begin
                        state_nxt = ST_WAIT_PE;
                    end else begin
                        cal_nxt   = 1'b1;
                        state_nxt = ST_PULSE;
                    end
                end
            end

            ST_WAIT_PE: begin
                if (pe_done) begin
                    rfd_nxt   = 1'b1;
                    cal_nxt   = last_q;
                    state_nxt = ST_PULSE;
                end
            end

            ST_PULSE: begin
                if (mode_q) begin
                    if (last_q) begin
                        wei_ptr_nxt = '0;
                        if (kr_q == KR_LAST) row_end = 1'b1;
                        else                 kr_nxt  = kr_q + 1'b1;
                    end
                end else begin
                    if (wei_ptr_q == POS_LAST) row_end     = 1'b1;
                    else                       wei_ptr_nxt = wei_ptr_q + 1'b1;
                end

                state_nxt = ST_SCAN;
                if (row_end) begin
                    kr_nxt      = '0;
                    wei_ptr_nxt = '0;
                    if (row_index == ROW_LAST) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        row_index_nxt = row_index + 1'b1;
                    end
                end
            end

            ST_DONE: state_nxt = ST_IDLE;

            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            mode_q            <= 1'b0;
            flag_q            <= '0;
            kr_q              <= '0;
            wei_ptr_q         <= '0;
            last_q            <= 1'b0;
            mc_start          <= 1'b0;
            row_finish_done_0 <= 1'b0;
            row_cal_done      <= 1'b0;
            wei_index         <= '0;
            row_index         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            protocol_err      <= 1'b0;
        end else begin
            state_q           <= state_nxt;
            mode_q            <= mode_nxt;
            flag_q            <= flag_nxt;
            kr_q              <= kr_nxt;
            wei_ptr_q         <= wei_ptr_nxt;
            last_q            <= last_nxt;
            mc_start          <= mc_start_nxt;
            row_finish_done_0 <= rfd_nxt;
            row_cal_done      <= cal_nxt;
            wei_index         <= wei_index_nxt;
            row_index         <= row_index_nxt;
            busy              <= busy_nxt;
            done              <= done_nxt;
            protocol_err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pe_row_scheduler.sv
// tb/tb_pe_row_scheduler.sv - scoreboard bench for pe_row_scheduler
module tb_pe_row_scheduler;

    localparam int IF_W = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode = 1'b0;
    logic       cfg_load = 1'b0;
    logic [8:0] cfg_wei_flag = '0;
    logic       go = 1'b0;
    logic       mc_en = 1'b0;
    logic       pe_done = 1'b0;
    logic       mc_start, rfd, cal, busy, done, perr;
    logic [3:0] wei_index, row_index;

    always #5 clk = ~clk;

    pe_row_scheduler #(.IF_WIDTH(IF_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .mode              (mode),
        .cfg_load          (cfg_load),
        .cfg_wei_flag      (cfg_wei_flag),
        .go                (go),
        .mc_en             (mc_en),
        .pe_done           (pe_done),
        .mc_start          (mc_start),
        .row_finish_done_0 (rfd),
        .row_cal_done      (cal),
        .wei_index         (wei_index),
        .row_index         (row_index),
        .busy              (busy),
        .done              (done),
        .protocol_err      (perr)
    );

    typedef struct {
        bit rfd;
        bit cal;
        bit is_done;
        int row;
        int wei;
        bit chk_wei;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        plan_q[$];
    ev_t        mon_e;
    int         errors = 0;
    int         checks = 0;
    int         rfd_cnt = 0;
    int         cal_cnt = 0;
    logic [8:0] model_flag = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: every kernel row of every feature-map row yields one pass per
    // set weight; a zero group (mode 1) or zero position (mode 0) yields a
    // completion pulse with no pass. Then one done.
    function automatic void build_model(input bit m, input logic [8:0] f);
        ev_t e;
        int  cols[$];
        plan_q.delete();
        for (int r = 0; r < IF_W; r++) begin
            if (m) begin
                for (int kr = 0; kr < 3; kr++) begin
                    cols.delete();
                    for (int c = 0; c < 3; c++) if (f[3*kr+c]) cols.push_back(c);
                    if (cols.size() == 0) begin
                        e.rfd = 0; e.cal = 1; e.is_done = 0; e.row = r; e.wei = 0; e.chk_wei = 0;
                        plan_q.push_back(e);
                    end else begin
                        for (int k = 0; k < cols.size(); k++) begin
                            e.rfd = 1; e.cal = (k == cols.size() - 1); e.is_done = 0;
                            e.row = r; e.wei = 3*kr + cols[k]; e.chk_wei = 1;
                            plan_q.push_back(e);
                        end
                    end
                end
            end else begin
                for (int p = 0; p < 9; p++) begin
                    e.rfd = f[p]; e.cal = 1; e.is_done = 0; e.row = r; e.wei = p; e.chk_wei = 1;
                    plan_q.push_back(e);
                end
            end
        end
        e.rfd = 0; e.cal = 0; e.is_done = 1; e.row = IF_W - 1; e.wei = 0; e.chk_wei = 0;
        plan_q.push_back(e);
    endfunction

    // Monitor: every pulse/done the DUT presents is matched against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && (rfd || cal || done)) begin
                if (rfd) rfd_cnt++;
                if (cal) cal_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: rfd=%0d cal=%0d done=%0d row=%0d required none",
                             rfd, cal, done, row_index);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ev_rfd", 32'(rfd), 32'(mon_e.rfd));
                    check("ev_cal", 32'(cal), 32'(mon_e.cal));
                    check("ev_done", 32'(done), 32'(mon_e.is_done));
                    check("ev_row", 32'(row_index), 32'(mon_e.row));
                    if (mon_e.chk_wei) check("ev_wei", 32'(wei_index), 32'(mon_e.wei));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_pulse(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(rfd || cal) && lat < 40);
        if (!(rfd || cal)) begin
            checks++;
            errors++;
            $display("FAIL pulse_timeout: no pulse within %0d cycles, required one", lat);
            lat = -1;
        end
    endtask

    task automatic hard_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        pe_done = 1'b0;
        mc_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_flag = '0;
    endtask

    task automatic run_pass(input bit m, input logic [8:0] f, input bit load,
                            input int mc_delay, input bit disturb, input int abort_row);
        int lat;
        int d;
        bit quiet;
        if (load) model_flag = f;
        build_model(m, model_flag);
        exp_q = plan_q;
        rfd_cnt = 0;
        cal_cnt = 0;

        @(posedge clk); #1;
        mode = m; go = 1'b1; cfg_load = load; cfg_wei_flag = f;
        @(posedge clk); #1;
        go = 1'b0; cfg_load = 1'b0; cfg_wei_flag = ~f;
        check("mc_start_on_go", 32'(mc_start), 32'd1);
        check("busy_on_go", 32'(busy), 32'd1);
        check("perr_cleared_by_go", 32'(perr), 32'd0);
        @(posedge clk); #1;
        check("mc_start_one_cycle", 32'(mc_start), 32'd0);

        if (disturb) begin
            go = 1'b1; cfg_load = 1'b1; mode = ~m;
            @(posedge clk); #1;
            go = 1'b0; cfg_load = 1'b0; pe_done = 1'b1;
            @(posedge clk); #1;
            pe_done = 1'b0;
            check("perr_stray_pe_done", 32'(perr), 32'd1);
        end

        quiet = 1'b1;
        for (int i = 0; i < mc_delay; i++) begin
            @(posedge clk); #1;
            if (rfd || cal || done) quiet = 1'b0;
        end
        if (mc_delay > 0) check("quiet_before_mc_en", 32'(quiet), 32'd1);
        mc_en = 1'b1;

        for (int i = 0; i < plan_q.size(); i++) begin
            if (plan_q[i].is_done) break;
            if (plan_q[i].rfd) begin
                if (plan_q[i].row == abort_row) begin
                    repeat (2) @(posedge clk);
                    #1;
                    reset = 1'b1;
                    exp_q.delete();
                    @(posedge clk); #1;
                    reset = 1'b0;
                    mc_en = 1'b0;
                    model_flag = '0;
                    check("reset_mid_pass_outputs",
                          32'({mc_start, rfd, cal, wei_index, row_index, busy, done, perr}), 32'd0);
                    @(negedge clk);
                    check("reset_mid_pass_idle", 32'({busy, mc_start, rfd, cal}), 32'd0);
                    return;
                end
                d = $urandom_range(2, 6);
                repeat (d) @(posedge clk);
                #1 pe_done = 1'b1;
                @(posedge clk); #1;
                pe_done = 1'b0;
                wait_pulse(lat);
                if (lat < 0) begin hard_reset(); return; end
                check("pe_done_to_pulse", 32'(lat), 32'd1);
            end else begin
                wait_pulse(lat);
                if (lat < 0) begin hard_reset(); return; end
                check("skip_pulse_spacing", 32'(lat), (i == 0) ? 32'd3 : 32'd2);
            end
        end

        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_during_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        mc_en = 1'b0;
        check("rfd_total", 32'(rfd_cnt), 32'($countones(model_flag) * IF_W));
        check("cal_total", 32'(cal_cnt), 32'((m ? 3 : 9) * IF_W));
        check("perr_at_end", 32'(perr), 32'(disturb));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({mc_start, rfd, cal, wei_index, row_index, busy, done, perr}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", 32'({busy, mc_start, done}), 32'd0);

        run_pass(1'b1, 9'b111_000_011, 1'b1, 0, 1'b0, -1);
        run_pass(1'b0, 9'b000_000_101, 1'b1, 2, 1'b0, -1);
        run_pass(1'b1, 9'($urandom), 1'b1, 20, 1'b1, -1);
        run_pass(1'b0, 9'($urandom), 1'b1, $urandom_range(0, 5), 1'b0, -1);
        run_pass(1'b1, 9'b111_000_011, 1'b1, 0, 1'b0, 7);
        // Flag register was cleared by reset: a pass without a load sees zeros.
        run_pass(1'b1, 9'h1FF, 1'b0, 1, 1'b0, -1);
        run_pass(1'b1, 9'b111_000_011, 1'b1, 0, 1'b0, -1);
        for (int k = 0; k < 3; k++)
            run_pass(1'($urandom), 9'($urandom), 1'b1, $urandom_range(0, 4), 1'($urandom), -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
